// File: rtl/adder_bist_ctrl.sv
// -----------------------------------------------------------------------------
// adder_bist_ctrl
// Built-in self-test initiator for the 16-bit dual-adder comparison checker.
// It drives a fixed set of directed corner operands into the checker, then
// LFSR pseudo-random operands. The checker's difference outputs are sampled
// CHK_LAT cycles after each vector. Mismatches are counted, and the first
// failing operand pair is captured.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         begin a run (honoured only in IDLE or DONE)
//   a, b          registered operands to the checker
//   check         sum difference from the checker
//   checkcout     carry difference from the checker
//   busy          high while issuing vectors or draining the response pipe
//   done          level high once the run has completed
//   pass          done and no mismatch seen
//   err_count     mismatching vectors (saturating)
//   vec_count     vectors checked so far
//   first_fail_a  a of the first mismatching vector
//   first_fail_b  b of the first mismatching vector
// -----------------------------------------------------------------------------
module adder_bist_ctrl #(
   parameter int          WIDTH       = 16,
   parameter int          NUM_VECTORS = 1024,
   parameter int          CHK_LAT     = 0,
   parameter logic [15:0] SEED_A      = 16'hACE1,
   parameter logic [15:0] SEED_B      = 16'h1D2F
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] check,
   input  logic             checkcout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] err_count,
   output logic [WIDTH-1:0] vec_count,
   output logic [WIDTH-1:0] first_fail_a,
   output logic [WIDTH-1:0] first_fail_b
);

   // A zero seed would lock the LFSR, so it is replaced with 1.
   localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
   localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == '0) ? WIDTH'(1) : SEED_B;
   localparam logic [15:0]      NV16       = 16'(NUM_VECTORS);
   localparam logic [1:0]       LAT_M1     = 2'(CHK_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIRECTED,
      S_RANDOM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
   logic [2:0]       dir_idx_q, dir_idx_d;
   logic [15:0]      rnd_cnt_q, rnd_cnt_d;
   logic [1:0]       drain_cnt_q, drain_cnt_d;
   logic             iv_q, iv_d;          // a_q/b_q hold a freshly issued vector
   logic [WIDTH-1:0] err_q, err_d, vec_q, vec_d;
   logic [WIDTH-1:0] ffa_q, ffa_d, ffb_q, ffb_d;

   logic             smp_valid;
   logic [WIDTH-1:0] smp_a, smp_b;

   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

   // Directed corner vectors, packed as {a, b}.
   function automatic logic [2*WIDTH-1:0] dir_vec(input logic [2:0] idx);
      case (idx)
         3'd0:    return {16'h0000, 16'h0000};
         3'd1:    return {16'hFFFF, 16'h0001};
         3'd2:    return {16'hFFFF, 16'hFFFF};
         3'd3:    return {16'hAAAA, 16'h5555};
         default: return {16'h8000, 16'h8000};
      endcase
   endfunction

   // Response alignment: each stage carries the issue flag plus the operands,
   // so the sampled result is always tied to the vector that caused it.
   generate
      if (CHK_LAT == 0) begin : g_nolat
         assign smp_valid = iv_q;
         assign smp_a     = a_q;
         assign smp_b     = b_q;
      end else begin : g_lat
         genvar gi;
         for (gi = 0; gi < CHK_LAT; gi++) begin : g_stage
            logic             v_q, v_d;
            logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
            if (gi == 0) begin : g_head
               always_comb begin
                  v_d  = iv_q;
                  sa_d = a_q;
                  sb_d = b_q;
               end
            end else begin : g_tail
               always_comb begin
                  v_d  = g_stage[gi-1].v_q;
                  sa_d = g_stage[gi-1].sa_q;
                  sb_d = g_stage[gi-1].sb_q;
               end
            end
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  v_q  <= 1'b0;
                  sa_q <= '0;
                  sb_q <= '0;
               end else begin
                  v_q  <= v_d;
                  sa_q <= sa_d;
                  sb_q <= sb_d;
               end
            end
         end
         assign smp_valid = g_stage[CHK_LAT-1].v_q;
         assign smp_a     = g_stage[CHK_LAT-1].sa_q;
         assign smp_b     = g_stage[CHK_LAT-1].sb_q;
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      lfsr_a_d    = lfsr_a_q;
      lfsr_b_d    = lfsr_b_q;
      dir_idx_d   = dir_idx_q;
      rnd_cnt_d   = rnd_cnt_q;
      drain_cnt_d = drain_cnt_q;
      iv_d        = 1'b0;
      err_d       = err_q;
      vec_d       = vec_q;
      ffa_d       = ffa_q;
      ffb_d       = ffb_q;

      // Result accumulation; no sample can be pending in IDLE/DONE, so the
      // clear on start below never collides with it.
      if (smp_valid) begin
         vec_d = vec_q + 1'b1;
         if ((|check) | checkcout) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) begin
               ffa_d = smp_a;
               ffb_d = smp_b;
            end
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_DIRECTED;
               {a_d, b_d}   = dir_vec(3'd0);
               iv_d         = 1'b1;
               dir_idx_d    = 3'd0;
               rnd_cnt_d    = '0;
               drain_cnt_d  = '0;
               lfsr_a_d     = SEED_A_EFF;
               lfsr_b_d     = SEED_B_EFF;
               err_d        = '0;
               vec_d        = '0;
               ffa_d        = '0;
               ffb_d        = '0;
            end
         end
         S_DIRECTED: begin
            iv_d = 1'b1;
            if (dir_idx_q == 3'd4) begin
               // First random vector is the seed itself.
               state_d   = S_RANDOM;
               a_d       = lfsr_a_q;
               b_d       = lfsr_b_q;
               lfsr_a_d  = lfsr_next(lfsr_a_q);
               lfsr_b_d  = lfsr_next(lfsr_b_q);
               rnd_cnt_d = 16'd1;
            end else begin
               dir_idx_d  = dir_idx_q + 3'd1;
               {a_d, b_d} = dir_vec(dir_idx_q + 3'd1);
            end
         end
         S_RANDOM: begin
            if (rnd_cnt_q == NV16) begin
               drain_cnt_d = '0;
               state_d     = (CHK_LAT > 0) ? S_DRAIN : S_DONE;
            end else begin
               iv_d      = 1'b1;
               a_d       = lfsr_a_q;
               b_d       = lfsr_b_q;
               lfsr_a_d  = lfsr_next(lfsr_a_q);
               lfsr_b_d  = lfsr_next(lfsr_b_q);
               rnd_cnt_d = rnd_cnt_q + 16'd1;
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == LAT_M1) state_d = S_DONE;
            else drain_cnt_d = drain_cnt_q + 2'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         lfsr_a_q    <= SEED_A_EFF;
         lfsr_b_q    <= SEED_B_EFF;
         dir_idx_q   <= '0;
         rnd_cnt_q   <= '0;
         drain_cnt_q <= '0;
         iv_q        <= 1'b0;
         err_q       <= '0;
         vec_q       <= '0;
         ffa_q       <= '0;
         ffb_q       <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         lfsr_a_q    <= lfsr_a_d;
         lfsr_b_q    <= lfsr_b_d;
         dir_idx_q   <= dir_idx_d;
         rnd_cnt_q   <= rnd_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         iv_q        <= iv_d;
         err_q       <= err_d;
         vec_q       <= vec_d;
         ffa_q       <= ffa_d;
         ffb_q       <= ffb_d;
      end
   end

   assign a            = a_q;
   assign b            = b_q;
   assign busy         = (state_q == S_DIRECTED) || (state_q == S_RANDOM) ||
                         (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE);
   assign pass         = done && (err_q == '0);
   assign err_count    = err_q;
   assign vec_count    = vec_q;
   assign first_fail_a = ffa_q;
   assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_bist_ctrl
// Two controllers (check latency 0 and 2, 16 random vectors each) share
// start/reset. Each one faces a behavioural responder whose fault pattern is
// chosen per run. The second responder delays its answer by two cycles.
// -----------------------------------------------------------------------------
module tb_adder_bist_ctrl;

   localparam int NV   = 16;
   localparam int NTOT = 5 + NV;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start;
   logic [15:0] a0, b0, chk0, err0, vec0, ffa0, ffb0;
   logic [15:0] a2, b2, chk2, err2, vec2, ffa2, ffb2;
   logic        cc0, cc2, busy0, done0, pass0, busy2, done2, pass2;

   // Responder fault configuration.
   logic [1:0]  mode;
   logic [15:0] fa, fb, mask, key;

   int tests  = 0;
   int failed = 0;

   logic [15:0] va[NTOT];
   logic [15:0] vb[NTOT];
   int          exp_err;
   logic [15:0] exp_ffa, exp_ffb;

   // Returns {carry_diff, sum_diff} for one operand pair.
   function automatic logic [16:0] resp(input logic [15:0] x, y, input logic [1:0] m,
                                        input logic [15:0] px, py, mk, ky);
      case (m)
         2'd1:    return (x == px && y == py) ? {1'b0, 16'h0001} : 17'd0;
         2'd2:    return {1'b1, 16'h0000};
         2'd3:    return (((x ^ y) & mk) == ky) ? {1'b0, 16'h8000} : 17'd0;
         default: return 17'd0;
      endcase
   endfunction

   assign {cc0, chk0} = resp(a0, b0, mode, fa, fb, mask, key);

   logic [16:0] dly1, dly2;
   always @(posedge clk) begin
      dly1 <= resp(a2, b2, mode, fa, fb, mask, key);
      dly2 <= dly1;
   end
   assign {cc2, chk2} = dly2;

   adder_bist_ctrl #(.WIDTH(16), .NUM_VECTORS(NV), .CHK_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0),
      .check(chk0), .checkcout(cc0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .vec_count(vec0), .first_fail_a(ffa0), .first_fail_b(ffb0));

   adder_bist_ctrl #(.WIDTH(16), .NUM_VECTORS(NV), .CHK_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2),
      .check(chk2), .checkcout(cc2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .vec_count(vec2), .first_fail_a(ffa2), .first_fail_b(ffb2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Operand stream the controller should issue: corner list, then the
   // maximal-length sequence from each seed.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb_bit;
      fb_bit = s[15] ^ s[13] ^ s[12] ^ s[10];   // taps of x^16+x^14+x^13+x^11+1
      return (s << 1) | {15'd0, fb_bit};
   endfunction

   task automatic build_stream();
      logic [15:0] sa, sb;
      va[0] = 16'h0000; vb[0] = 16'h0000;
      va[1] = 16'hFFFF; vb[1] = 16'h0001;
      va[2] = 16'hFFFF; vb[2] = 16'hFFFF;
      va[3] = 16'hAAAA; vb[3] = 16'h5555;
      va[4] = 16'h8000; vb[4] = 16'h8000;
      sa = 16'hACE1;
      sb = 16'h1D2F;
      for (int i = 5; i < NTOT; i++) begin
         va[i] = sa;
         vb[i] = sb;
         sa = lfsr_step(sa);
         sb = lfsr_step(sb);
      end
   endtask

   task automatic model_expect();
      exp_err = 0;
      exp_ffa = 16'h0;
      exp_ffb = 16'h0;
      for (int i = 0; i < NTOT; i++) begin
         if (resp(va[i], vb[i], mode, fa, fb, mask, key) != 17'd0) begin
            if (exp_err == 0) begin
               exp_ffa = va[i];
               exp_ffb = vb[i];
            end
            exp_err++;
         end
      end
   endtask

   // One full run on both controllers; optional second start mid-run.
   task automatic run_check(input string name, input int e_err, input logic [15:0] e_fa,
                            input logic [15:0] e_fb, input bit mid_start);
      int n, t0, t2, busy_cnt;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0; t0 = -1; t2 = -1; busy_cnt = 0;
      while ((t0 < 0 || t2 < 0) && n < 200) begin
         if (busy0) busy_cnt++;
         if (done0 && t0 < 0) t0 = n;
         if (done2 && t2 < 0) t2 = n;
         if (n < 7) begin
            chk($sformatf("%s a0[%0d]", name, n), {16'h0, a0}, {16'h0, va[n]});
            chk($sformatf("%s b2[%0d]", name, n), {16'h0, b2}, {16'h0, vb[n]});
         end
         start = mid_start && (n == 8);
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      chk({name, " done_cycle0"}, t0, 21);
      chk({name, " done_cycle2"}, t2, 23);
      chk({name, " busy_cycles0"}, busy_cnt, 21);
      chk({name, " err0"}, {16'h0, err0}, e_err);
      chk({name, " err2"}, {16'h0, err2}, e_err);
      chk({name, " vec0"}, {16'h0, vec0}, NTOT);
      chk({name, " vec2"}, {16'h0, vec2}, NTOT);
      chk({name, " ffa0"}, {16'h0, ffa0}, {16'h0, e_fa});
      chk({name, " ffb0"}, {16'h0, ffb0}, {16'h0, e_fb});
      chk({name, " ffa2"}, {16'h0, ffa2}, {16'h0, e_fa});
      chk({name, " ffb2"}, {16'h0, ffb2}, {16'h0, e_fb});
      chk({name, " pass0"}, {31'h0, pass0}, {31'h0, (e_err == 0)});
      chk({name, " pass2"}, {31'h0, pass2}, {31'h0, (e_err == 0)});
      $display("[TB] run %s: err=%0d/%0d vec=%0d/%0d first=(%h,%h) done@%0d/%0d",
               name, err0, err2, vec0, vec2, ffa0, ffb0, t0, t2);
   endtask

   task automatic check_idle_zero(input string name);
      chk({name, " outs0"}, {a0 | b0 | err0 | vec0 | ffa0 | ffb0, 13'h0, busy0, done0, pass0}, 32'h0);
      chk({name, " outs2"}, {a2 | b2 | err2 | vec2 | ffa2 | ffb2, 13'h0, busy2, done2, pass2}, 32'h0);
   endtask

   typedef struct {
      string       name;
      logic [1:0]  mode;
      logic [15:0] fa, fb;
      int          e_err;
      logic [15:0] e_fa, e_fb;
      bit          mid;
   } case_t;

   case_t tbl[5];

   initial begin
      tbl[0] = '{"healthy",   2'd0, 16'h0000, 16'h0000,  0, 16'h0000, 16'h0000, 1'b0};
      tbl[1] = '{"single",    2'd1, 16'hFFFF, 16'h0001,  1, 16'hFFFF, 16'h0001, 1'b0};
      tbl[2] = '{"stuck_cc",  2'd2, 16'h0000, 16'h0000, 21, 16'h0000, 16'h0000, 1'b0};
      tbl[3] = '{"lat_fault", 2'd1, 16'hAAAA, 16'h5555,  1, 16'hAAAA, 16'h5555, 1'b0};
      tbl[4] = '{"mid_start", 2'd0, 16'h0000, 16'h0000,  0, 16'h0000, 16'h0000, 1'b1};

      mode = 2'd0; fa = '0; fb = '0; mask = '0; key = '0;
      rst_n = 1'b0;
      start = 1'b1;               // reset must dominate start
      build_stream();
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst_n = 1'b1;
      start = 1'b0;
      chk("lfsr_a_stream5", {16'h0, va[5]}, 32'h0000ACE1);
      chk("lfsr_a_stream6", {16'h0, va[6]}, 32'h000059C3);

      for (int i = 0; i < 5; i++) begin
         mode = tbl[i].mode;
         fa   = tbl[i].fa;
         fb   = tbl[i].fb;
         run_check(tbl[i].name, tbl[i].e_err, tbl[i].e_fa, tbl[i].e_fb, tbl[i].mid);
      end

      // Reset in the middle of a failing run.
      mode = 2'd2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_idle_zero("mid_reset");
      mode = 2'd0;
      run_check("after_reset", 0, 16'h0, 16'h0, 1'b0);

      // Randomized fault patterns checked against the stream model.
      for (int r = 0; r < 6; r++) begin
         if (r % 2 == 0) begin
            int idx;
            idx  = $urandom_range(0, NTOT - 1);
            mode = 2'd1;
            fa   = va[idx];
            fb   = vb[idx];
         end else begin
            mode = 2'd3;
            mask = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
            key  = 16'($urandom) & mask;
         end
         model_expect();
         run_check($sformatf("rand%0d", r), exp_err, exp_ffa, exp_ffb, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
